// File: rtl/taxi_dma_ram_rd_arb.sv
// Segmented DMA RAM read-port arbiter: PORTS requesters share one RAM read port.
// Each segment arbitrates on its own and remembers the source of every outstanding read.
module taxi_dma_ram_rd_arb #(
  parameter int PORTS           = 2,
  parameter int SEGS            = 2,
  parameter int SEG_ADDR_W      = 8,
  parameter int SEG_DATA_W      = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int ARB_ROUND_ROBIN = 1
) (
  input  logic                               clk,
  input  logic                               rst,

  // requester ports, flattened: bit/slice index is (port*SEGS + seg)
  input  logic [PORTS*SEGS*SEG_ADDR_W-1:0]   s_rd_cmd_addr,
  input  logic [PORTS*SEGS-1:0]              s_rd_cmd_valid,
  output logic [PORTS*SEGS-1:0]              s_rd_cmd_ready,
  output logic [PORTS*SEGS*SEG_DATA_W-1:0]   s_rd_resp_data,
  output logic [PORTS*SEGS-1:0]              s_rd_resp_valid,
  input  logic [PORTS*SEGS-1:0]              s_rd_resp_ready,

  // shared RAM read port
  output logic [SEGS*SEG_ADDR_W-1:0]         m_rd_cmd_addr,
  output logic [SEGS-1:0]                    m_rd_cmd_valid,
  input  logic [SEGS-1:0]                    m_rd_cmd_ready,
  input  logic [SEGS*SEG_DATA_W-1:0]         m_rd_resp_data,
  input  logic [SEGS-1:0]                    m_rd_resp_valid,
  output logic [SEGS-1:0]                    m_rd_resp_ready,

  output logic [SEGS-1:0]                    stat_busy,
  output logic [SEGS-1:0]                    stat_orphan
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; a valid command holds addr until accepted.

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  if (PORTS < 2) begin : g_bad_ports
    $fatal(1, "taxi_dma_ram_rd_arb: PORTS must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "taxi_dma_ram_rd_arb: FIFO_DEPTH must be a power of two >= 2");
  end

  for (genvar n = 0; n < SEGS; n++) begin : g_seg
    logic [PORTS-1:0] req;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] hold_port;
    logic             hold_valid;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] mem [FIFO_DEPTH];
    logic [IDX_W-1:0] head;
    logic             empty;
    logic             full;
    logic             room;
    logic             push;
    logic             pop;
    logic             orphan;

    always_comb begin
      req = '0;
      for (int p = 0; p < PORTS; p++) begin
        req[p] = s_rd_cmd_valid[p*SEGS + n];
      end
    end

    always_comb begin : arb
      int  idx;
      logic found;
      rr_pick = '0;
      found   = 1'b0;
      idx     = 0;
      if (ARB_ROUND_ROBIN != 0) begin
        for (int i = 1; i <= PORTS; i++) begin
          idx = (int'(last_grant) + i) % PORTS;
          if (!found && req[idx]) begin
            found   = 1'b1;
            rr_pick = IDX_W'(idx);
          end
        end
      end else begin
        for (int i = 0; i < PORTS; i++) begin
          if (!found && req[i]) begin
            found   = 1'b1;
            rr_pick = IDX_W'(i);
          end
        end
      end
    end

    // A requester that was winning but not yet accepted keeps the grant,
    // so a newcomer can never pull the command out from under it.
    assign winner    = (hold_valid && req[hold_port]) ? hold_port : rr_pick;
    assign any_valid = |req;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign head  = mem[rd_ptr[PTR_W-2:0]];

    assign pop  = !rst && m_rd_resp_valid[n] && !empty &&
                  s_rd_resp_ready[int'(head)*SEGS + n];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign room = !full || pop;
    assign push = !rst && m_rd_cmd_valid[n] && m_rd_cmd_ready[n];

    assign m_rd_cmd_valid[n] = any_valid && room;
    assign m_rd_cmd_addr[n*SEG_ADDR_W +: SEG_ADDR_W] = any_valid ?
      s_rd_cmd_addr[(int'(winner)*SEGS + n)*SEG_ADDR_W +: SEG_ADDR_W] : '0;
    assign m_rd_resp_ready[n] = !rst && !empty &&
                                s_rd_resp_ready[int'(head)*SEGS + n];
    assign stat_busy[n]   = !empty;
    assign stat_orphan[n] = orphan;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign s_rd_cmd_ready[p*SEGS + n]  = !rst && any_valid && (winner == IDX_W'(p)) &&
                                           m_rd_cmd_ready[n] && room;
      assign s_rd_resp_valid[p*SEGS + n] = !rst && m_rd_resp_valid[n] && !empty &&
                                           (head == IDX_W'(p));
      assign s_rd_resp_data[(p*SEGS + n)*SEG_DATA_W +: SEG_DATA_W] =
        m_rd_resp_data[n*SEG_DATA_W +: SEG_DATA_W];
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[PTR_W-2:0]] <= winner;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        last_grant <= IDX_W'(PORTS - 1);
        hold_valid <= 1'b0;
        hold_port  <= '0;
        orphan     <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + PTR_W'(1);
          last_grant <= winner;
          hold_valid <= 1'b0;
        end else if (any_valid) begin
          hold_valid <= 1'b1;
          hold_port  <= winner;
        end else begin
          hold_valid <= 1'b0;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (m_rd_resp_valid[n] && empty) begin
          orphan <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_taxi_dma_ram_rd_arb.sv
// Bench for taxi_dma_ram_rd_arb: directed scenarios then random traffic,
// checked cycle by cycle against a queue-based reference model.
module tb_taxi_dma_ram_rd_arb;
  localparam int PORTS = 2;
  localparam int SEGS  = 2;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int NK    = PORTS * SEGS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NK*AW-1:0]   s_rd_cmd_addr;
  logic [NK-1:0]      s_rd_cmd_valid;
  logic [NK-1:0]      s_rd_cmd_ready;
  logic [NK*DW-1:0]   s_rd_resp_data;
  logic [NK-1:0]      s_rd_resp_valid;
  logic [NK-1:0]      s_rd_resp_ready;
  logic [SEGS*AW-1:0] m_rd_cmd_addr;
  logic [SEGS-1:0]    m_rd_cmd_valid;
  logic [SEGS-1:0]    m_rd_cmd_ready;
  logic [SEGS*DW-1:0] m_rd_resp_data;
  logic [SEGS-1:0]    m_rd_resp_valid;
  logic [SEGS-1:0]    m_rd_resp_ready;
  logic [SEGS-1:0]    stat_busy;
  logic [SEGS-1:0]    stat_orphan;

  taxi_dma_ram_rd_arb #(
    .PORTS(PORTS), .SEGS(SEGS), .SEG_ADDR_W(AW), .SEG_DATA_W(DW),
    .FIFO_DEPTH(DEPTH), .ARB_ROUND_ROBIN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_rd_cmd_addr(s_rd_cmd_addr), .s_rd_cmd_valid(s_rd_cmd_valid),
    .s_rd_cmd_ready(s_rd_cmd_ready), .s_rd_resp_data(s_rd_resp_data),
    .s_rd_resp_valid(s_rd_resp_valid), .s_rd_resp_ready(s_rd_resp_ready),
    .m_rd_cmd_addr(m_rd_cmd_addr), .m_rd_cmd_valid(m_rd_cmd_valid),
    .m_rd_cmd_ready(m_rd_cmd_ready), .m_rd_resp_data(m_rd_resp_data),
    .m_rd_resp_valid(m_rd_resp_valid), .m_rd_resp_ready(m_rd_resp_ready),
    .stat_busy(stat_busy), .stat_orphan(stat_orphan)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0] ram [SEGS][256];
  bit            act [NK];
  logic [AW-1:0] req_addr [NK];
  logic [AW-1:0] addr_q [NK][$];
  logic [DW-1:0] exp_q [NK][$];
  int            rx_count [NK];
  logic [DW-1:0] last_rx [NK];
  int            id_q [SEGS][$];
  int            last_grant [SEGS];
  int            hold [SEGS];
  logic [DW-1:0] ram_data_q [SEGS][$];
  int            ram_due_q [SEGS][$];
  bit            orphan_m [SEGS];
  int            grant_log [SEGS][$];

  bit rnd_mode   = 1'b0;
  int p_req      = 0;
  int p_cmd_rdy  = 100;
  int p_resp_rdy = 100;
  bit resp_block [NK];
  int cmd_stall  [SEGS];
  bit inject     [SEGS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Grant history of a segment packed as decimal digits (port+1), oldest first.
  function automatic int glog(input int n);
    int v = 0;
    for (int i = 0; i < grant_log[n].size() && i < 8; i++) v = v * 10 + grant_log[n][i] + 1;
    return v;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NK; k++) begin
      act[k] = 1'b0;
      addr_q[k].delete();
      exp_q[k].delete();
      rx_count[k] = 0;
      last_rx[k] = '0;
      resp_block[k] = 1'b0;
    end
    for (int n = 0; n < SEGS; n++) begin
      id_q[n].delete();
      ram_data_q[n].delete();
      ram_due_q[n].delete();
      grant_log[n].delete();
      last_grant[n] = PORTS - 1;
      hold[n] = -1;
      orphan_m[n] = 1'b0;
      cmd_stall[n] = 0;
      inject[n] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_rd_cmd_valid  = '1;
    s_rd_resp_ready = '1;
    m_rd_cmd_ready  = '1;
    m_rd_resp_valid = '0;
    clear_model();
    @(negedge clk);
    #1;
    check("rst_cmd_ready", 64'(s_rd_cmd_ready), 64'd0);
    check("rst_resp_valid", 64'(s_rd_resp_valid), 64'd0);
    check("rst_busy", 64'(stat_busy), 64'd0);
    check("rst_orphan", 64'(stat_orphan), 64'd0);
    rst = 1'b0;
    s_rd_cmd_valid  = '0;
    s_rd_resp_ready = '0;
    m_rd_cmd_ready  = '0;
  endtask

  task automatic step();
    int  win [SEGS];
    int  head [SEGS];
    bit  anyv [SEGS];
    bit  pop [SEGS];
    bit  push [SEGS];
    bit  mrv [SEGS];
    bit  room;
    int  k;
    @(negedge clk);
    for (int kk = 0; kk < NK; kk++) begin
      if (!act[kk]) begin
        if (addr_q[kk].size() > 0) begin
          act[kk] = 1'b1;
          req_addr[kk] = addr_q[kk].pop_front();
        end else if (rnd_mode && $urandom_range(99) < p_req) begin
          act[kk] = 1'b1;
          req_addr[kk] = AW'($urandom);
        end
      end
      s_rd_cmd_valid[kk] = act[kk];
      s_rd_cmd_addr[kk*AW +: AW] = act[kk] ? req_addr[kk] : AW'($urandom);
      s_rd_resp_ready[kk] = !resp_block[kk] && ($urandom_range(99) < p_resp_rdy);
    end
    for (int n = 0; n < SEGS; n++) begin
      if (cmd_stall[n] > 0) begin
        m_rd_cmd_ready[n] = 1'b0;
        cmd_stall[n]--;
      end else begin
        m_rd_cmd_ready[n] = ($urandom_range(99) < p_cmd_rdy);
      end
      mrv[n] = (ram_due_q[n].size() > 0 && ram_due_q[n][0] <= cyc) || inject[n];
      m_rd_resp_valid[n] = mrv[n];
      m_rd_resp_data[n*DW +: DW] = (ram_data_q[n].size() > 0) ? ram_data_q[n][0] : DW'($urandom);
    end
    #1;
    for (int n = 0; n < SEGS; n++) begin
      anyv[n] = 1'b0;
      for (int p = 0; p < PORTS; p++) if (act[p*SEGS + n]) anyv[n] = 1'b1;
      win[n] = -1;
      if (hold[n] >= 0 && act[hold[n]*SEGS + n]) win[n] = hold[n];
      else for (int i = 1; i <= PORTS; i++) begin
        int c = (last_grant[n] + i) % PORTS;
        if (win[n] < 0 && act[c*SEGS + n]) win[n] = c;
      end
      head[n] = (id_q[n].size() > 0) ? id_q[n][0] : -1;
      pop[n]  = mrv[n] && head[n] >= 0 && s_rd_resp_ready[head[n]*SEGS + n];
      room    = (id_q[n].size() < DEPTH) || pop[n];
      push[n] = anyv[n] && room && m_rd_cmd_ready[n];

      check($sformatf("m_cmd_valid[%0d]", n), 64'(m_rd_cmd_valid[n]), 64'(anyv[n] && room));
      check($sformatf("m_cmd_addr[%0d]", n), 64'(m_rd_cmd_addr[n*AW +: AW]),
            anyv[n] ? 64'(req_addr[win[n]*SEGS + n]) : 64'd0);
      check($sformatf("m_resp_ready[%0d]", n), 64'(m_rd_resp_ready[n]),
            64'(head[n] >= 0 && s_rd_resp_ready[(head[n] < 0 ? 0 : head[n])*SEGS + n]));
      check($sformatf("busy[%0d]", n), 64'(stat_busy[n]), 64'(id_q[n].size() > 0));
      check($sformatf("orphan[%0d]", n), 64'(stat_orphan[n]), 64'(orphan_m[n]));
      for (int p = 0; p < PORTS; p++) begin
        k = p*SEGS + n;
        check($sformatf("s_cmd_ready[p%0d s%0d]", p, n), 64'(s_rd_cmd_ready[k]),
              64'(anyv[n] && win[n] == p && m_rd_cmd_ready[n] && room));
        check($sformatf("s_resp_valid[p%0d s%0d]", p, n), 64'(s_rd_resp_valid[k]),
              64'(mrv[n] && head[n] == p));
        if (pop[n] && head[n] == p) begin
          logic [DW-1:0] e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : '0;
          check($sformatf("resp_data[p%0d s%0d]", p, n), 64'(s_rd_resp_data[k*DW +: DW]), 64'(e));
          last_rx[k] = s_rd_resp_data[k*DW +: DW];
          rx_count[k]++;
        end
      end
    end
    for (int n = 0; n < SEGS; n++) begin
      if (pop[n]) begin
        void'(id_q[n].pop_front());
        if (ram_data_q[n].size() > 0) begin
          void'(ram_data_q[n].pop_front());
          void'(ram_due_q[n].pop_front());
        end
      end
      if (mrv[n] && head[n] < 0) orphan_m[n] = 1'b1;
      if (push[n]) begin
        k = win[n]*SEGS + n;
        id_q[n].push_back(win[n]);
        exp_q[k].push_back(ram[n][req_addr[k]]);
        ram_data_q[n].push_back(ram[n][req_addr[k]]);
        ram_due_q[n].push_back(cyc + LAT);
        grant_log[n].push_back(win[n]);
        last_grant[n] = win[n];
        hold[n] = -1;
        act[k] = 1'b0;
      end else begin
        hold[n] = anyv[n] ? win[n] : -1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    s_rd_cmd_addr = '0; s_rd_cmd_valid = '0; s_rd_resp_ready = '0;
    m_rd_cmd_ready = '0; m_rd_resp_data = '0; m_rd_resp_valid = '0;
    for (int s = 0; s < SEGS; s++) for (int a = 0; a < 256; a++) ram[s][a] = DW'($urandom);
    ram[0][8'h10] = 16'h00AA;

    // single read, port 0 seg 0
    do_reset();
    addr_q[0].push_back(8'h10);
    run(8);
    check("t1_data", 64'(last_rx[0]), 64'h00AA);
    check("t1_count", 64'(rx_count[0]), 64'd1);
    check("t1_other_port", 64'(rx_count[2]), 64'd0);

    // two ports contend on seg 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      addr_q[0].push_back(8'h01);
      addr_q[2].push_back(8'h02);
    end
    run(20);
    check("t2_grants", 64'(glog(0)), 64'd12121212);
    check("t2_rx0", 64'(rx_count[0]), 64'd4);
    check("t2_rx1", 64'(rx_count[2]), 64'd4);
    check("t2_seg1_idle", 64'(grant_log[1].size()), 64'd0);

    // fill the ID FIFO behind a stalled responder
    do_reset();
    resp_block[2] = 1'b1;
    for (int i = 0; i < 5; i++) addr_q[2].push_back(AW'(8'h20 + i));
    run(10);
    check("t3_full_valid", 64'(m_rd_cmd_valid[0]), 64'd0);
    check("t3_accepted", 64'(grant_log[0].size()), 64'd4);
    resp_block[2] = 1'b0;
    run(1);
    check("t3_accept_on_pop", 64'(grant_log[0].size()), 64'd5);
    run(12);
    check("t3_rx", 64'(rx_count[2]), 64'd5);

    // grant held through a command stall
    do_reset();
    addr_q[0].push_back(8'h33);
    cmd_stall[0] = 3;
    run(1);
    addr_q[2].push_back(8'h44);
    run(8);
    check("t4_hold_p0", 64'(glog(0)), 64'd12);
    do_reset();
    addr_q[2].push_back(8'h55);
    cmd_stall[0] = 3;
    run(1);
    addr_q[0].push_back(8'h66);
    run(8);
    check("t4_hold_p1", 64'(glog(0)), 64'd21);

    // orphan response on seg 1
    do_reset();
    inject[1] = 1'b1;
    run(1);
    inject[1] = 1'b0;
    run(1);
    check("t5_orphan1", 64'(stat_orphan[1]), 64'd1);
    check("t5_orphan0", 64'(stat_orphan[0]), 64'd0);
    do_reset();
    addr_q[0].push_back(8'h07);
    addr_q[2].push_back(8'h08);
    run(8);
    check("t5_first_win", 64'(glog(0)), 64'd12);

    // random traffic with mid-transfer resets between rounds
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rnd_mode   = 1'b1;
      p_req      = $urandom_range(30, 90);
      p_cmd_rdy  = $urandom_range(40, 100);
      p_resp_rdy = $urandom_range(30, 100);
      run(700);
    end
    rnd_mode = 1'b0;
    p_cmd_rdy = 100;
    p_resp_rdy = 100;
    run(40);
    for (int k = 0; k < NK; k++) check($sformatf("drain[%0d]", k), 64'(exp_q[k].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
